// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy/fill bus master.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [3:0]  WSTRB_WORD = 4'hF;
   localparam logic [3:0]  WSTRB_NONE = 4'h0;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive stalled bus cycles; expired_o flags the cycle whose edge
// would bring the count to TIMEOUT. TIMEOUT=0 disables it.
module mem_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired_o = 1'b0;
      end else begin : g_on
         assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!enable_i || clear_i || expired_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mem_copy_master.sv
// Word copy / fill initiator on the picorv32 native memory bus, with watchdog abort.
// Fill mode exists only when MEM_COPY_FILL_EN is defined; otherwise every transfer copies.
module mem_copy_master
   import mem_copy_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   input  logic             fill_mode,
   input  logic [31:0]      fill_data,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   output logic             mem_instr,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_rdata
);

   state_t           state_q;
   logic [31:0]      src_q, dst_q;
   logic [LEN_W-1:0] len_q, words_done_q;
   logic             busy_q, done_q, error_q, fill_q;
   logic             mem_valid_q;
   logic [31:0]      mem_addr_q, mem_wdata_q;
   logic [3:0]       mem_wstrb_q;

   logic [31:0]      src_d, dst_d;
   logic [LEN_W-1:0] words_done_d;
   logic             last_word, fill_req, wd_expired;

   assign src_d        = src_q + WORD_BYTES;
   assign dst_d        = dst_q + WORD_BYTES;
   assign words_done_d = words_done_q + 1'b1;
   assign last_word    = (words_done_d == len_q);

`ifdef MEM_COPY_FILL_EN
   assign fill_req = fill_mode;
`else
   assign fill_req = 1'b0;
   logic unused_fill;
   assign unused_fill = ^{fill_mode, fill_data};
`endif

   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (mem_valid_q),
      .clear_i   (mem_ready),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         words_done_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         fill_q       <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= WSTRB_NONE;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         // expired_o is already qualified by a pending, unanswered request
         if (wd_expired) begin
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     src_q        <= word_align(src_addr);
                     dst_q        <= word_align(dst_addr);
                     len_q        <= len_words;
                     words_done_q <= '0;
                     fill_q       <= fill_req;
`ifdef MEM_COPY_FILL_EN
                     mem_wdata_q  <= fill_data;
`endif
                     if (len_words == '0) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                     end else if (fill_req) begin
                        busy_q      <= 1'b1;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= word_align(dst_addr);
                        mem_wstrb_q <= WSTRB_WORD;
                        state_q     <= WR;
                     end else begin
                        busy_q      <= 1'b1;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= word_align(src_addr);
                        mem_wstrb_q <= WSTRB_NONE;
                        state_q     <= RD;
                     end
                  end
               end
               RD: begin
                  if (mem_ready) begin
                     mem_wdata_q <= mem_rdata;
                     src_q       <= src_d;
                     mem_addr_q  <= dst_q;
                     mem_wstrb_q <= WSTRB_WORD;
                     state_q     <= WR;
                  end
               end
               WR: begin
                  if (mem_ready) begin
                     dst_q        <= dst_d;
                     words_done_q <= words_done_d;
                     if (last_word) begin
                        mem_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                     end else if (fill_q) begin
                        mem_addr_q <= dst_d;
                     end else begin
                        // src_q was advanced when the previous read completed
                        mem_addr_q  <= src_q;
                        mem_wstrb_q <= WSTRB_NONE;
                        state_q     <= RD;
                     end
                  end
               end
               FIN:     state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign words_done = words_done_q;
   assign mem_valid  = mem_valid_q;
   assign mem_instr  = 1'b0;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;

endmodule
